spsa_phase_scheduler: RTL and testbench

Sequences one A-SPSA iteration in the 1 MHz domain. Each iteration runs +perturbation write, shadow swap, settle, error measurement, then −perturbation write, swap, settle, measurement, then commit write and a final swap. It drives the weight-write engine through a mode/start/done handshake and the shadow memory through a four-phase swap handshake. It averages the error metric per phase and aborts/restores when the temperature bank changes.

---
 rtl/spsa_phase_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spsa_phase_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spsa_phase_scheduler.sv
// -----------------------------------------------------------------------------
// spsa_phase_scheduler
//
// Sequences one A-SPSA iteration in the SPSA clock domain:
//   +perturbation write, shadow swap, settle, measure,
//   -perturbation write, shadow swap, settle, measure,
//   commit write, shadow swap.
// A temperature-bank change aborts the iteration and runs a restore write
// followed by a swap.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   enable           run iterations (sampled in IDLE and when SWP_COM exits)
//   bank_changed     one-cycle pulse, aborts an iteration in progress
//   wr_start/wr_mode/wr_done   weight-write engine handshake
//   swap_req/swap_ack          shadow-memory four-phase swap handshake
//   err_in/err_valid           signed error samples
//   j_pos/j_neg/j_valid        per-phase mean error, j_valid pulses once per
//                              completed measurement pair
//   iter_count       completed iterations (wraps)
//   abort_count      aborted iterations (saturates)
//   fault            sticky swap-timeout flag
//   busy, state      debug view of the sequencer
//
// Handshakes
//   Write engine: wr_start is a one-cycle pulse on the first cycle a WR_*
//   state may issue it; wr_mode is stable from state entry until the state
//   exits. Only a wr_done seen after wr_start was issued, while still in
//   that WR_* state, completes the pass.
//   Swap: swap_req rises on SWP_* entry, falls on the cycle after swap_ack=1
//   is seen, and the state exits when swap_ack=0 is seen. Each edge wait is
//   limited to SWAP_TIMEOUT cycles; expiry sets fault and returns to IDLE.
// -----------------------------------------------------------------------------
module spsa_phase_scheduler #(
    parameter int ERR_WIDTH     = 16,
    parameter int ACC_WIDTH     = 32,
    parameter int LOG2_SAMPLES  = 6,
    parameter int SETTLE_CYCLES = 64,
    parameter int SWAP_TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 bank_changed,
    output logic                 wr_start,
    output logic [1:0]           wr_mode,
    input  logic                 wr_done,
    output logic                 swap_req,
    input  logic                 swap_ack,
    input  logic [ERR_WIDTH-1:0] err_in,
    input  logic                 err_valid,
    output logic [ACC_WIDTH-1:0] j_pos,
    output logic [ACC_WIDTH-1:0] j_neg,
    output logic                 j_valid,
    output logic [15:0]          iter_count,
    output logic [7:0]           abort_count,
    output logic                 fault,
    output logic                 busy,
    output logic [3:0]           state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_POS    = 4'd1;
    localparam logic [3:0] S_SWP_POS   = 4'd2;
    localparam logic [3:0] S_SET_POS   = 4'd3;
    localparam logic [3:0] S_MEAS_POS  = 4'd4;
    localparam logic [3:0] S_WR_NEG    = 4'd5;
    localparam logic [3:0] S_SWP_NEG   = 4'd6;
    localparam logic [3:0] S_SET_NEG   = 4'd7;
    localparam logic [3:0] S_MEAS_NEG  = 4'd8;
    localparam logic [3:0] S_WR_COM    = 4'd9;
    localparam logic [3:0] S_SWP_COM   = 4'd10;
    localparam logic [3:0] S_ABORT_WR  = 4'd11;
    localparam logic [3:0] S_ABORT_SWP = 4'd12;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TO_LAST     = 32'(SWAP_TIMEOUT - 1);
    localparam logic [LOG2_SAMPLES:0] SMP_LAST = (LOG2_SAMPLES + 1)'((1 << LOG2_SAMPLES) - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [3:0]                   state_q, state_d;
    logic                         swap_phase_q;     // 0: waiting ack=1, 1: waiting ack=0
    logic                         drain_q;          // abort hit mid-swap, wait for ack=0
    logic                         start_pending_q;  // wr_start not yet issued in this WR_* state
    logic [31:0]                  cnt_q;            // settle / swap-edge timeout counter
    logic [LOG2_SAMPLES:0]        smp_cnt_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]         j_pos_q, j_neg_q;
    logic                         j_valid_q;
    logic [1:0]                   wr_mode_q;
    logic [15:0]                  iter_q;
    logic [7:0]                   abort_q;
    logic                         fault_q;

    logic in_seq, in_wr, in_swp, in_set, in_meas;
    logic abort_now, wr_fire, wr_fin, swp_ack_seen, swp_done, swp_to, drain_to;
    logic settle_done, smp_take, meas_last, entering;
    logic signed [ACC_WIDTH-1:0] err_ext, acc_next, mean_c;
    logic signed [ACC_WIDTH:0]   sum_w;

    assign in_seq  = (state_q >= S_WR_POS) && (state_q <= S_SWP_COM);
    assign in_wr   = (state_q == S_WR_POS) || (state_q == S_WR_NEG) ||
                     (state_q == S_WR_COM) || (state_q == S_ABORT_WR);
    assign in_swp  = (state_q == S_SWP_POS) || (state_q == S_SWP_NEG) ||
                     (state_q == S_SWP_COM) || (state_q == S_ABORT_SWP);
    assign in_set  = (state_q == S_SET_POS) || (state_q == S_SET_NEG);
    assign in_meas = (state_q == S_MEAS_POS) || (state_q == S_MEAS_NEG);

    assign abort_now    = bank_changed && in_seq;
    assign wr_fire      = in_wr && start_pending_q && !drain_q;
    assign wr_fin       = in_wr && !start_pending_q && wr_done;
    assign swp_ack_seen = in_swp && !swap_phase_q && swap_ack;
    assign swp_done     = in_swp && swap_phase_q && !swap_ack;
    assign swp_to       = in_swp && !swp_ack_seen && !swp_done && (cnt_q == TO_LAST);
    assign drain_to     = (state_q == S_ABORT_WR) && drain_q && swap_ack && (cnt_q == TO_LAST);
    assign settle_done  = in_set && (cnt_q == SETTLE_LAST);
    assign smp_take     = in_meas && err_valid;
    assign meas_last    = smp_take && (smp_cnt_q == SMP_LAST);

    // Saturating accumulate: one guard bit detects overflow, then clamp.
    assign err_ext = ACC_WIDTH'($signed(err_in));
    assign sum_w   = (ACC_WIDTH + 1)'(acc_q) + (ACC_WIDTH + 1)'(err_ext);
    always_comb begin
        if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
            acc_next = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_w[ACC_WIDTH-1:0];
        end
    end
    assign mean_c = acc_next >>> LOG2_SAMPLES;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort overrides every other event this cycle.
    always_comb begin
        state_d = state_q;
        if (abort_now) begin
            state_d = S_ABORT_WR;
        end else begin
            case (state_q)
                S_IDLE:      if (enable && !fault_q) state_d = S_WR_POS;
                S_WR_POS:    if (wr_fin) state_d = S_SWP_POS;
                S_WR_NEG:    if (wr_fin) state_d = S_SWP_NEG;
                S_WR_COM:    if (wr_fin) state_d = S_SWP_COM;
                S_ABORT_WR: begin
                    if (drain_to)    state_d = S_IDLE;
                    else if (wr_fin) state_d = S_ABORT_SWP;
                end
                S_SWP_POS: begin
                    if (swp_to)        state_d = S_IDLE;
                    else if (swp_done) state_d = S_SET_POS;
                end
                S_SWP_NEG: begin
                    if (swp_to)        state_d = S_IDLE;
                    else if (swp_done) state_d = S_SET_NEG;
                end
                S_SWP_COM: begin
                    if (swp_to)        state_d = S_IDLE;
                    else if (swp_done) state_d = enable ? S_WR_POS : S_IDLE;
                end
                S_ABORT_SWP: if (swp_to || swp_done) state_d = S_IDLE;
                S_SET_POS:   if (settle_done) state_d = S_MEAS_POS;
                S_SET_NEG:   if (settle_done) state_d = S_MEAS_NEG;
                S_MEAS_POS:  if (meas_last) state_d = S_WR_NEG;
                S_MEAS_NEG:  if (meas_last) state_d = S_WR_COM;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    assign entering = (state_d != state_q);

    // Datapath and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_phase_q    <= 1'b0;
            drain_q         <= 1'b0;
            start_pending_q <= 1'b0;
            cnt_q           <= '0;
            smp_cnt_q       <= '0;
            acc_q           <= '0;
            j_pos_q         <= '0;
            j_neg_q         <= '0;
            j_valid_q       <= 1'b0;
            wr_mode_q       <= 2'd0;
            iter_q          <= '0;
            abort_q         <= '0;
            fault_q         <= 1'b0;
        end else begin
            // Counter restarts on every state entry and on each swap edge.
            if (entering || swp_ack_seen ||
                ((state_q == S_ABORT_WR) && drain_q && !swap_ack)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end

            if (entering)          swap_phase_q <= 1'b0;
            else if (swp_ack_seen) swap_phase_q <= 1'b1;

            if (entering)     start_pending_q <= (state_d == S_WR_POS) || (state_d == S_WR_NEG) ||
                                                 (state_d == S_WR_COM) || (state_d == S_ABORT_WR);
            else if (wr_fire) start_pending_q <= 1'b0;

            // Abort taken from a swap state: the shadow memory may still hold ack.
            if (entering)                                               drain_q <= (state_d == S_ABORT_WR) && in_swp;
            else if ((state_q == S_ABORT_WR) && drain_q && !swap_ack)   drain_q <= 1'b0;

            if (entering) begin
                case (state_d)
                    S_WR_POS:   wr_mode_q <= 2'd0;
                    S_WR_NEG:   wr_mode_q <= 2'd1;
                    S_WR_COM:   wr_mode_q <= 2'd2;
                    S_ABORT_WR: wr_mode_q <= 2'd3;
                    default:    wr_mode_q <= wr_mode_q;
                endcase
            end

            if (entering) begin
                acc_q     <= '0;
                smp_cnt_q <= '0;
            end else if (smp_take) begin
                acc_q     <= acc_next;
                smp_cnt_q <= smp_cnt_q + 1'b1;
            end

            if ((state_q == S_MEAS_POS) && (state_d == S_WR_NEG)) j_pos_q <= mean_c;
            if ((state_q == S_MEAS_NEG) && (state_d == S_WR_COM)) j_neg_q <= mean_c;
            j_valid_q <= (state_q == S_MEAS_NEG) && (state_d == S_WR_COM);

            if ((state_q == S_SWP_COM) && swp_done && !abort_now) iter_q <= iter_q + 16'd1;
            if ((state_q == S_ABORT_SWP) && swp_done && (abort_q != 8'hFF)) abort_q <= abort_q + 8'd1;

            if ((swp_to || drain_to) && !abort_now)   fault_q <= 1'b1;
            else if ((state_q == S_IDLE) && !enable)  fault_q <= 1'b0;
        end
    end

    // Outputs; swap_req decodes from registered state so reset drops it at once.
    always_comb begin
        busy     = (state_q != S_IDLE);
        swap_req = in_swp && !swap_phase_q;
        wr_start = wr_fire;
    end

    assign wr_mode     = wr_mode_q;
    assign j_pos       = j_pos_q;
    assign j_neg       = j_neg_q;
    assign j_valid     = j_valid_q;
    assign iter_count  = iter_q;
    assign abort_count = abort_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_spsa_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spsa_phase_scheduler
//
// Bench for spsa_phase_scheduler with ACC_WIDTH=18, LOG2_SAMPLES=4,
// SETTLE_CYCLES=4, SWAP_TIMEOUT=16. A write-engine model answers wr_start
// with wr_done three cycles later; a shadow-memory model answers swap_req
// with swap_ack two cycles later (or holds ack low). Expected per-phase means
// are computed from the driven samples and queued; they are compared when
// j_valid pulses.
// -----------------------------------------------------------------------------
module tb_spsa_phase_scheduler;

    localparam int ERR_W     = 16;
    localparam int ACC_W     = 18;
    localparam int L2        = 4;
    localparam int SETTLE    = 4;
    localparam int TMO       = 16;
    localparam int NS        = 1 << L2;
    localparam int ACC_MAX_I = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN_I = -(1 << (ACC_W - 1));

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_POS   = 4'd1;
    localparam logic [3:0] S_SET_POS  = 4'd3;
    localparam logic [3:0] S_MEAS_POS = 4'd4;
    localparam logic [3:0] S_SWP_NEG  = 4'd6;
    localparam logic [3:0] S_MEAS_NEG = 4'd8;
    localparam logic [3:0] S_ABORT_WR = 4'd11;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             bank_changed;
    logic             wr_start;
    logic [1:0]       wr_mode;
    logic             wr_done;
    logic             swap_req;
    logic             swap_ack;
    logic [ERR_W-1:0] err_in;
    logic             err_valid;
    logic [ACC_W-1:0] j_pos;
    logic [ACC_W-1:0] j_neg;
    logic             j_valid;
    logic [15:0]      iter_count;
    logic [7:0]       abort_count;
    logic             fault;
    logic             busy;
    logic [3:0]       state;

    logic [31:0] exp_q[$];
    logic [3:0]  state_log[$];
    logic [1:0]  mode_log[$];

    int   n_checks     = 0;
    int   n_fail       = 0;
    int   jv_count     = 0;
    int   swap_rises   = 0;
    int   req_run      = 0;
    int   last_req_run = 0;
    logic ack_hold     = 1'b0;

    spsa_phase_scheduler #(
        .ERR_WIDTH     (ERR_W),
        .ACC_WIDTH     (ACC_W),
        .LOG2_SAMPLES  (L2),
        .SETTLE_CYCLES (SETTLE),
        .SWAP_TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .bank_changed (bank_changed),
        .wr_start     (wr_start),
        .wr_mode      (wr_mode),
        .wr_done      (wr_done),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .err_in       (err_in),
        .err_valid    (err_valid),
        .j_pos        (j_pos),
        .j_neg        (j_neg),
        .j_valid      (j_valid),
        .iter_count   (iter_count),
        .abort_count  (abort_count),
        .fault        (fault),
        .busy         (busy),
        .state        (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // ---------------- write engine model ----------------
    initial begin : engine_model
        int cnt;
        cnt     = 0;
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) wr_done = 1'b1;
            end else if (wr_start) begin
                cnt = 3;
                mode_log.push_back(wr_mode);
            end
        end
    end

    // ---------------- shadow memory swap model ----------------
    initial begin : swap_model
        logic [1:0] req_d;
        logic       prev_req;
        req_d    = 2'b00;
        prev_req = 1'b0;
        swap_ack = 1'b0;
        forever begin
            @(negedge clk);
            swap_ack = ack_hold ? 1'b0 : req_d[1];
            req_d    = {req_d[0], swap_req};
            if (swap_req && !prev_req) swap_rises++;
            if (swap_req) begin
                req_run++;
            end else if (prev_req) begin
                last_req_run = req_run;
                req_run      = 0;
            end
            prev_req = swap_req;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [3:0]  last_st;
        logic [31:0] ep;
        logic [31:0] en;
        last_st = S_IDLE;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_st = S_IDLE;
            end else begin
                if (state != last_st) begin
                    state_log.push_back(state);
                    last_st = state;
                end
                if (j_valid) begin
                    jv_count++;
                    check("jv_with_wr_start", 32'(wr_start), 32'd1);
                    check("jv_wr_mode", 32'(wr_mode), 32'd2);
                    if (exp_q.size() >= 2) begin
                        ep = exp_q.pop_front();
                        en = exp_q.pop_front();
                        check("sb_j_pos", 32'($signed(j_pos)), ep);
                        check("sb_j_neg", 32'($signed(j_neg)), en);
                    end else begin
                        check("sb_expected_available", 32'(exp_q.size()), 32'd2);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [3:0] st, input string tag);
        int n;
        n = 0;
        while (state !== st && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    // Drives NS samples of val once state st is reached, with random gaps.
    // While waiting, err_valid is held high with junk that must be ignored.
    // abort_at >= 0 pulses bank_changed together with that sample index.
    task automatic run_meas(input logic [3:0] st, input int val, input int abort_at);
        int acc;
        int n;
        int gap;
        acc = 0;
        n   = 0;
        while (state !== st && n < 3000) begin
            err_valid = 1'b1;
            err_in    = 16'h5A5A;
            @(negedge clk);
            n++;
        end
        err_valid = 1'b0;
        check("meas_reached", 32'(state), 32'(st));
        for (int i = 0; i < NS; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                err_valid = 1'b0;
                @(negedge clk);
            end
            err_valid = 1'b1;
            err_in    = 16'(val);
            acc       = acc + val;
            if (acc > ACC_MAX_I) acc = ACC_MAX_I;
            if (acc < ACC_MIN_I) acc = ACC_MIN_I;
            if (i == abort_at) begin
                bank_changed = 1'b1;
                @(negedge clk);
                bank_changed = 1'b0;
                err_valid    = 1'b0;
                return;
            end
            if (i == NS - 1) exp_q.push_back(32'(acc >>> L2));
            @(negedge clk);
        end
        err_valid = 1'b0;
    endtask

    function automatic int rand_err();
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int rises0;
        int nm;
        int n;
        logic [31:0] pos_exp;

        rst          = 1'b0;
        enable       = 1'b0;
        bank_changed = 1'b0;
        err_in       = '0;
        err_valid    = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_swap_req", 32'(swap_req), 32'd0);
        check("rst_wr_start", 32'(wr_start), 32'd0);
        check("rst_wr_mode", 32'(wr_mode), 32'd0);
        check("rst_j_pos", 32'(j_pos), 32'd0);
        check("rst_j_valid", 32'(j_valid), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        check("rst_abort", 32'(abort_count), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: nominal iteration, +100 / -40
        state_log.delete();
        mode_log.delete();
        enable = 1'b1;
        wait_state(S_WR_POS, "t1_start");
        enable = 1'b0;
        run_meas(S_MEAS_POS, 100, -1);
        run_meas(S_MEAS_NEG, -40, -1);
        wait_state(S_IDLE, "t1_idle");
        check("t1_log_len", 32'(state_log.size()), 32'd11);
        for (int i = 0; i < state_log.size() && i < 11; i++) begin
            check("t1_state_order", 32'(state_log[i]), (i < 10) ? 32'(i + 1) : 32'd0);
        end
        check("t1_j_pos", 32'($signed(j_pos)), 32'd100);
        check("t1_j_neg", 32'($signed(j_neg)), -32'sd40);
        check("t1_iter", 32'(iter_count), 32'd1);
        check("t1_jv_count", 32'(jv_count), 32'd1);
        check("t1_wr_passes", 32'(mode_log.size()), 32'd3);
        for (int i = 0; i < mode_log.size() && i < 3; i++) begin
            check("t1_wr_mode_seq", 32'(mode_log[i]), 32'(i));
        end
        check("t1_busy", 32'(busy), 32'd0);

        // Test 2: accumulator saturation both ways
        enable = 1'b1;
        wait_state(S_WR_POS, "t2_start");
        enable = 1'b0;
        run_meas(S_MEAS_POS, 32767, -1);
        run_meas(S_MEAS_NEG, -32768, -1);
        wait_state(S_IDLE, "t2_idle");
        check("t2_j_pos_clamp", 32'($signed(j_pos)), 32'd8191);
        check("t2_j_neg_clamp", 32'($signed(j_neg)), -32'sd8192);
        check("t2_iter", 32'(iter_count), 32'd2);

        // Test 3: abort in MEAS_NEG after two samples, with a third sample
        rises0 = swap_rises;
        nm     = mode_log.size();
        enable = 1'b1;
        wait_state(S_WR_POS, "t3_start");
        enable = 1'b0;
        run_meas(S_MEAS_POS, rand_err(), -1);
        pos_exp = exp_q.pop_back();
        run_meas(S_MEAS_NEG, rand_err(), 2);
        check("t3_abort_state", 32'(state), 32'(S_ABORT_WR));
        check("t3_abort_wr_mode", 32'(wr_mode), 32'd3);
        check("t3_swap_req_low", 32'(swap_req), 32'd0);
        wait_state(S_IDLE, "t3_idle");
        check("t3_abort_count", 32'(abort_count), 32'd1);
        check("t3_iter_kept", 32'(iter_count), 32'd2);
        check("t3_no_j_valid", 32'(jv_count), 32'd2);
        check("t3_passes", 32'(mode_log.size()), 32'(nm + 3));
        if (mode_log.size() > 0) check("t3_last_mode", 32'(mode_log[mode_log.size() - 1]), 32'd3);
        check("t3_swaps", 32'(swap_rises - rises0), 32'd3);
        check("t3_j_pos", 32'($signed(j_pos)), pos_exp);
        check("t3_j_neg_kept", 32'($signed(j_neg)), -32'sd8192);

        // bank_changed in IDLE is ignored
        bank_changed = 1'b1;
        @(negedge clk);
        bank_changed = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_bank_state", 32'(state), 32'd0);
        check("idle_bank_abort", 32'(abort_count), 32'd1);

        // Test 4: swap timeout
        ack_hold = 1'b1;
        enable   = 1'b1;
        n        = 0;
        while (fault !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_req_len", 32'(last_req_run), 32'(TMO));
        check("t4_state", 32'(state), 32'd0);
        check("t4_swap_req", 32'(swap_req), 32'd0);
        repeat (20) @(negedge clk);
        check("t4_no_restart", 32'(state), 32'd0);
        check("t4_fault_sticky", 32'(fault), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t4_fault_clear", 32'(fault), 32'd0);
        ack_hold = 1'b0;
        repeat (3) @(negedge clk);

        // Test 5: enable dropped in SET_POS, iteration still completes
        enable = 1'b1;
        wait_state(S_SET_POS, "t5_set_pos");
        enable = 1'b0;
        run_meas(S_MEAS_POS, rand_err(), -1);
        run_meas(S_MEAS_NEG, rand_err(), -1);
        wait_state(S_IDLE, "t5_idle");
        check("t5_iter", 32'(iter_count), 32'd3);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_jv_count", 32'(jv_count), 32'd3);
        repeat (5) @(negedge clk);
        check("t5_stays_idle", 32'(state), 32'd0);

        // Test 6: asynchronous reset during SWP_NEG
        enable = 1'b1;
        wait_state(S_WR_POS, "t6_start");
        enable = 1'b0;
        run_meas(S_MEAS_POS, rand_err(), -1);
        void'(exp_q.pop_back());
        wait_state(S_SWP_NEG, "t6_swp_neg");
        check("t6_req_before", 32'(swap_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_swap_req", 32'(swap_req), 32'd0);
        check("t6_state", 32'(state), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_wr_mode", 32'(wr_mode), 32'd0);
        check("t6_iter", 32'(iter_count), 32'd0);
        check("t6_abort", 32'(abort_count), 32'd0);
        check("t6_j_pos", 32'(j_pos), 32'd0);
        check("t6_j_neg", 32'(j_neg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
